// File: rtl/ita_oup_stream_buffer.sv
// ita_oup_stream_buffer
// Output row buffer for the ITA datapath, placed after the activation stage.
// N-lane rows pushed by the pipeline are held in a DEPTH-row FIFO and handed
// out as SPLIT narrower beats under valid/ready backpressure. calc_ready_o
// drops early enough that PIPE_LAT rows already in flight still fit.
// Optional peak-usage monitor: define ITA_OUP_USAGE_MON_EN.

module ita_oup_stream_buffer #(
    parameter int N        = 16,
    parameter int WI       = 8,
    parameter int DEPTH    = 8,
    parameter int SPLIT    = 1,
    parameter int PIPE_LAT = 6
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [N*WI-1:0]              data_i,
    output logic                         calc_ready_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [(N/SPLIT)*WI-1:0]      oup_o,
    output logic                         last_o,
    output logic [$clog2(DEPTH+1)-1:0]   usage_o,
    output logic                         overflow_o,
    output logic [$clog2(DEPTH+1)-1:0]   usage_max_o
);

    localparam int ROW_W  = N * WI;
    localparam int BEAT_W = (N / SPLIT) * WI;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int BCNT_W = (SPLIT > 1) ? $clog2(SPLIT) : 1;

    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  PIPE_LAT_C = CNT_W'(PIPE_LAT);
    localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(DEPTH - 1);
    localparam logic [BCNT_W-1:0] BEAT_LAST  = BCNT_W'(SPLIT - 1);

    // Parameter sanity: rows must split evenly and the stall slack must fit.
    if (N % SPLIT != 0) begin : g_badSplit
        $error("ita_oup_stream_buffer: N must be a multiple of SPLIT");
    end
    if (DEPTH <= PIPE_LAT) begin : g_badSlack
        $error("ita_oup_stream_buffer: DEPTH must exceed PIPE_LAT");
    end
    if (DEPTH < 2) begin : g_badDepth
        $error("ita_oup_stream_buffer: DEPTH must be at least 2");
    end

    logic [ROW_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_usage;
    logic [BCNT_W-1:0] r_beat;
    logic              r_overflow;

    logic              w_valid;
    logic              w_lastBeat;
    logic              w_beatAcc;
    logic              w_pop;
    logic              w_room;
    logic              w_pushAcc;
    logic              w_drop;
    logic [ROW_W-1:0]  w_row;
    logic [BEAT_W-1:0] w_beatData;

    // A full FIFO still takes a push when the head row leaves in the same cycle;
    // flush wins over both push and pop.
    assign w_valid    = (r_usage != '0);
    assign w_lastBeat = (r_beat == BEAT_LAST);
    assign w_beatAcc  = w_valid && ready_i && !flush_i;
    assign w_pop      = w_beatAcc && w_lastBeat;
    assign w_room     = (r_usage < DEPTH_C) || w_pop;
    assign w_pushAcc  = push_i && !flush_i && w_room;
    assign w_drop     = push_i && !flush_i && !w_room;
    assign w_row      = r_mem[r_rdPtr];

    // Row storage; unreset because contents are only observed once usage covers them.
    always_ff @(posedge clk_i) begin
        if (w_pushAcc) begin
            r_mem[r_wrPtr] <= data_i;
        end
    end

    // Pointers, occupancy, beat position and sticky overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_usage    <= '0;
            r_beat     <= '0;
            r_overflow <= 1'b0;
        end else if (flush_i) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_usage    <= '0;
            r_beat     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pushAcc) begin
                r_wrPtr <= (r_wrPtr == PTR_LAST) ? '0 : r_wrPtr + PTR_W'(1);
            end
            if (w_beatAcc) begin
                if (w_lastBeat) begin
                    r_beat  <= '0;
                    r_rdPtr <= (r_rdPtr == PTR_LAST) ? '0 : r_rdPtr + PTR_W'(1);
                end else begin
                    r_beat <= r_beat + BCNT_W'(1);
                end
            end
            case ({w_pushAcc, w_pop})
                2'b10:   r_usage <= r_usage + CNT_W'(1);
                2'b01:   r_usage <= r_usage - CNT_W'(1);
                default: r_usage <= r_usage;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Select the slice of the head row addressed by the current beat.
    always_comb begin
        w_beatData = '0;
        for (int b = 0; b < SPLIT; b++) begin
            if (r_beat == BCNT_W'(b)) begin
                w_beatData = w_row[b*BEAT_W +: BEAT_W];
            end
        end
    end

    assign valid_o      = w_valid;
    assign oup_o        = w_valid ? w_beatData : '0;
    assign last_o       = w_valid && w_lastBeat;
    assign usage_o      = r_usage;
    assign overflow_o   = r_overflow;
    assign calc_ready_o = (DEPTH_C - r_usage) > PIPE_LAT_C;

`ifdef ITA_OUP_USAGE_MON_EN
    logic [CNT_W-1:0] r_usageMax;
    logic             r_validPrev;

    // Peak occupancy since reset/flush; bounded by DEPTH because usage is.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_usageMax  <= '0;
            r_validPrev <= 1'b0;
        end else if (flush_i) begin
            r_usageMax  <= '0;
            r_validPrev <= 1'b0;
        end else begin
            if (r_usage > r_usageMax) begin
                r_usageMax <= r_usage;
            end
            r_validPrev <= w_valid;
        end
    end

`ifndef SYNTHESIS
    // Report the peak each time the buffer drains after a busy run.
    always @(posedge clk_i) begin
        if (rst_ni && !flush_i && r_validPrev && !w_valid) begin
            $display("ita_oup_stream_buffer: drained, peak usage %0d", r_usageMax);
        end
    end
`endif

    assign usage_max_o = r_usageMax;
`else
    assign usage_max_o = '0;
`endif

endmodule

// File: tb/tb_ita_oup_stream_buffer.sv
// tb_ita_oup_stream_buffer
// Self-checking bench: three buffers (SPLIT = 1, 4, 2) with DEPTH=8, PIPE_LAT=6.
// Expected beats are queued when rows are pushed and popped on each handshake.

module tb_ita_oup_stream_buffer;

    localparam int N        = 16;
    localparam int WI       = 8;
    localparam int DEPTH    = 8;
    localparam int PIPE_LAT = 6;
    localparam int ROW_W    = N * WI;

    logic clk_i = 1'b0;
    logic rst_ni;

    always #5 clk_i = ~clk_i;

    // SPLIT=1 instance
    logic              flush1, push1, ready1;
    logic [ROW_W-1:0]  data1;
    logic              calcRdy1, valid1, last1, ovf1;
    logic [127:0]      oup1;
    logic [3:0]        usage1, umax1;

    // SPLIT=4 instance
    logic              flush4, push4, ready4;
    logic [ROW_W-1:0]  data4;
    logic              calcRdy4, valid4, last4, ovf4;
    logic [31:0]       oup4;
    logic [3:0]        usage4, umax4;

    // SPLIT=2 instance
    logic              flush2, push2, ready2;
    logic [ROW_W-1:0]  data2;
    logic              calcRdy2, valid2, last2, ovf2;
    logic [63:0]       oup2;
    logic [3:0]        usage2, umax2;

    ita_oup_stream_buffer #(.N(N), .WI(WI), .DEPTH(DEPTH), .SPLIT(1), .PIPE_LAT(PIPE_LAT)) u1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush1), .push_i(push1), .data_i(data1),
        .calc_ready_o(calcRdy1), .valid_o(valid1), .ready_i(ready1), .oup_o(oup1),
        .last_o(last1), .usage_o(usage1), .overflow_o(ovf1), .usage_max_o(umax1));

    ita_oup_stream_buffer #(.N(N), .WI(WI), .DEPTH(DEPTH), .SPLIT(4), .PIPE_LAT(PIPE_LAT)) u4 (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush4), .push_i(push4), .data_i(data4),
        .calc_ready_o(calcRdy4), .valid_o(valid4), .ready_i(ready4), .oup_o(oup4),
        .last_o(last4), .usage_o(usage4), .overflow_o(ovf4), .usage_max_o(umax4));

    ita_oup_stream_buffer #(.N(N), .WI(WI), .DEPTH(DEPTH), .SPLIT(2), .PIPE_LAT(PIPE_LAT)) u2 (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush2), .push_i(push2), .data_i(data2),
        .calc_ready_o(calcRdy2), .valid_o(valid2), .ready_i(ready2), .oup_o(oup2),
        .last_o(last2), .usage_o(usage2), .overflow_o(ovf2), .usage_max_o(umax2));

    int compared   = 0;
    int mismatched = 0;

    // Expected beats: {last, data}
    logic [128:0] q1[$];
    logic [32:0]  q4[$];
    logic [64:0]  q2[$];

    function automatic logic [ROW_W-1:0] randRow();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Asynchronous reset state of every instance.
    task automatic test_reset();
        rst_ni = 1'b0;
        {flush1, push1, ready1} = '0; data1 = '0;
        {flush4, push4, ready4} = '0; data4 = '0;
        {flush2, push2, ready2} = '0; data2 = '0;
        #1;
        compared++; if (valid1 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid1: got %b want 0", valid1); end
        compared++; if (oup1 !== '0) begin mismatched++; $display("[TB] FAIL reset_oup1: got %h want 0", oup1); end
        compared++; if (last1 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_last1: got %b want 0", last1); end
        compared++; if (usage1 !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_usage1: got %0d want 0", usage1); end
        compared++; if (ovf1 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ovf1: got %b want 0", ovf1); end
        compared++; if (calcRdy1 !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_calcRdy1: got %b want 1", calcRdy1); end
        compared++; if (valid4 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid4: got %b want 0", valid4); end
        compared++; if (valid2 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid2: got %b want 0", valid2); end
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        compared++; if (usage1 !== 4'd0) begin mismatched++; $display("[TB] FAIL post_reset_usage1: got %0d want 0", usage1); end
    endtask

    // One row through the SPLIT=1 buffer with ready held high.
    task automatic test_single_row();
        logic [ROW_W-1:0] row;
        logic [128:0]     exp;
        row = 128'h100F0E0D0C0B0A090807060504030201;
        push1 = 1'b1; data1 = row; ready1 = 1'b1;
        q1.push_back({1'b1, row});
        @(negedge clk_i);
        push1 = 1'b0;
        compared++; if (valid1 !== 1'b1) begin mismatched++; $display("[TB] FAIL single_valid: got %b want 1", valid1); end
        compared++; if (usage1 !== 4'd1) begin mismatched++; $display("[TB] FAIL single_usage: got %0d want 1", usage1); end
        exp = q1.pop_front();
        compared++; if (oup1 !== exp[127:0]) begin mismatched++; $display("[TB] FAIL single_oup: got %h want %h", oup1, exp[127:0]); end
        compared++; if (last1 !== exp[128]) begin mismatched++; $display("[TB] FAIL single_last: got %b want %b", last1, exp[128]); end
        @(negedge clk_i);
        compared++; if (valid1 !== 1'b0) begin mismatched++; $display("[TB] FAIL single_drained_valid: got %b want 0", valid1); end
        compared++; if (usage1 !== 4'd0) begin mismatched++; $display("[TB] FAIL single_drained_usage: got %0d want 0", usage1); end
        compared++; if (oup1 !== '0) begin mismatched++; $display("[TB] FAIL single_idle_oup: got %h want 0", oup1); end
    endtask

    // One row through the SPLIT=4 buffer: four 4-lane beats, last on beat 3.
    task automatic test_split4();
        logic [ROW_W-1:0] row;
        logic [32:0]      exp;
        int               beats;
        row = randRow();
        push4 = 1'b1; data4 = row; ready4 = 1'b1;
        for (int b = 0; b < 4; b++) q4.push_back({(b == 3), row[b*32 +: 32]});
        @(negedge clk_i);
        push4 = 1'b0;
        compared++; if (valid4 !== 1'b1) begin mismatched++; $display("[TB] FAIL split4_first_valid: got %b want 1", valid4); end
        beats = 0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk_i);
            if (valid4) begin
                if (q4.size() == 0) begin
                    compared++; mismatched++;
                    $display("[TB] FAIL split4_extra_beat: got oup %h want no beat", oup4);
                end else begin
                    exp = q4.pop_front();
                    compared++; if (oup4 !== exp[31:0]) begin mismatched++; $display("[TB] FAIL split4_oup_beat%0d: got %h want %h", beats, oup4, exp[31:0]); end
                    compared++; if (last4 !== exp[32]) begin mismatched++; $display("[TB] FAIL split4_last_beat%0d: got %b want %b", beats, last4, exp[32]); end
                end
                beats++;
            end
        end
        compared++; if (beats !== 4) begin mismatched++; $display("[TB] FAIL split4_beat_count: got %0d want 4", beats); end
        compared++; if (usage4 !== 4'd0) begin mismatched++; $display("[TB] FAIL split4_usage_end: got %0d want 0", usage4); end
    endtask

    // Push every cycle with no drain: stall threshold, fill, dropped 9th row.
    task automatic test_overflow();
        logic [128:0] exp;
        logic         expRdy;
        logic         mOv;
        int           mu;
        mu = 0; mOv = 1'b0;
        ready1 = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk_i);
            expRdy = ((DEPTH - mu) > PIPE_LAT);
            compared++; if (usage1 !== 4'(mu)) begin mismatched++; $display("[TB] FAIL ovf_usage_n%0d: got %0d want %0d", n, usage1, mu); end
            compared++; if (calcRdy1 !== expRdy) begin mismatched++; $display("[TB] FAIL ovf_calcRdy_n%0d: got %b want %b", n, calcRdy1, expRdy); end
            compared++; if (ovf1 !== mOv) begin mismatched++; $display("[TB] FAIL ovf_flag_n%0d: got %b want %b", n, ovf1, mOv); end
            push1 = 1'b1; data1 = randRow();
            if (mu < DEPTH) begin
                mu++;
                q1.push_back({1'b1, data1});
            end else begin
                mOv = 1'b1;
            end
        end
        @(negedge clk_i);
        push1 = 1'b0;
        compared++; if (usage1 !== 4'd8) begin mismatched++; $display("[TB] FAIL ovf_full_usage: got %0d want 8", usage1); end
        compared++; if (ovf1 !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_set: got %b want 1", ovf1); end
        compared++; if (calcRdy1 !== 1'b0) begin mismatched++; $display("[TB] FAIL ovf_full_calcRdy: got %b want 0", calcRdy1); end
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk_i);
            ready1 = 1'b1;
            exp = q1.pop_front();
            compared++; if (oup1 !== exp[127:0]) begin mismatched++; $display("[TB] FAIL ovf_drain_row%0d: got %h want %h", k, oup1, exp[127:0]); end
        end
        @(negedge clk_i);
        compared++; if (usage1 !== 4'd0) begin mismatched++; $display("[TB] FAIL ovf_drained_usage: got %0d want 0", usage1); end
        compared++; if (ovf1 !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_sticky: got %b want 1", ovf1); end
        ready1 = 1'b0;
    endtask

    // Flush with five rows stored and a push pending.
    task automatic test_flush();
        for (int n = 0; n < 5; n++) begin
            @(negedge clk_i);
            push1 = 1'b1; data1 = randRow();
        end
        @(negedge clk_i);
        compared++; if (usage1 !== 4'd5) begin mismatched++; $display("[TB] FAIL flush_pre_usage: got %0d want 5", usage1); end
        flush1 = 1'b1; push1 = 1'b1; data1 = randRow();
        @(negedge clk_i);
        flush1 = 1'b0; push1 = 1'b0;
        compared++; if (usage1 !== 4'd0) begin mismatched++; $display("[TB] FAIL flush_usage: got %0d want 0", usage1); end
        compared++; if (valid1 !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_valid: got %b want 0", valid1); end
        compared++; if (ovf1 !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_ovf: got %b want 0", ovf1); end
        compared++; if (umax1 !== 4'd0) begin mismatched++; $display("[TB] FAIL flush_umax: got %0d want 0", umax1); end
        compared++; if (oup1 !== '0) begin mismatched++; $display("[TB] FAIL flush_oup: got %h want 0", oup1); end
        compared++; if (calcRdy1 !== 1'b1) begin mismatched++; $display("[TB] FAIL flush_calcRdy: got %b want 1", calcRdy1); end
        q1.delete();
    endtask

    // Full FIFO with a push and a row-completing pop in the same cycle.
    task automatic test_full_push_pop();
        logic [128:0] exp;
        ready1 = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk_i);
            push1 = 1'b1; data1 = randRow();
            q1.push_back({1'b1, data1});
        end
        @(negedge clk_i);
        compared++; if (usage1 !== 4'd8) begin mismatched++; $display("[TB] FAIL fpp_full_usage: got %0d want 8", usage1); end
        push1 = 1'b1; data1 = randRow(); ready1 = 1'b1;
        exp = q1.pop_front();
        compared++; if (oup1 !== exp[127:0]) begin mismatched++; $display("[TB] FAIL fpp_pop_row: got %h want %h", oup1, exp[127:0]); end
        q1.push_back({1'b1, data1});
        @(negedge clk_i);
        push1 = 1'b0;
        compared++; if (usage1 !== 4'd8) begin mismatched++; $display("[TB] FAIL fpp_usage_held: got %0d want 8", usage1); end
        compared++; if (ovf1 !== 1'b0) begin mismatched++; $display("[TB] FAIL fpp_no_ovf: got %b want 0", ovf1); end
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk_i);
            exp = q1.pop_front();
            compared++; if (oup1 !== exp[127:0]) begin mismatched++; $display("[TB] FAIL fpp_drain_row%0d: got %h want %h", k, oup1, exp[127:0]); end
        end
        @(negedge clk_i);
        compared++; if (usage1 !== 4'd0) begin mismatched++; $display("[TB] FAIL fpp_drained_usage: got %0d want 0", usage1); end
        ready1 = 1'b0;
    endtask

    // SPLIT=2, ready toggling 1010..., 20 rows streamed back to back.
    task automatic test_back_to_back();
        logic [64:0] exp;
        int          rowsPushed;
        int          beats;
        logic        holdPend;
        logic        done;
        rowsPushed = 0; beats = 0; holdPend = 1'b0; done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk_i);
            if (holdPend) begin
                compared++; if (valid2 !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_valid_held_c%0d: got %b want 1", c, valid2); end
                holdPend = 1'b0;
            end
            ready2 = (c % 2 == 0);
            if (valid2) begin
                if (q2.size() == 0) begin
                    compared++; mismatched++;
                    $display("[TB] FAIL b2b_extra_beat_c%0d: got oup %h want no beat", c, oup2);
                end else if (ready2) begin
                    exp = q2.pop_front();
                    compared++; if (oup2 !== exp[63:0]) begin mismatched++; $display("[TB] FAIL b2b_oup_beat%0d: got %h want %h", beats, oup2, exp[63:0]); end
                    compared++; if (last2 !== exp[64]) begin mismatched++; $display("[TB] FAIL b2b_last_beat%0d: got %b want %b", beats, last2, exp[64]); end
                    beats++;
                end else begin
                    exp = q2[0];
                    compared++; if (oup2 !== exp[63:0]) begin mismatched++; $display("[TB] FAIL b2b_stall_oup_c%0d: got %h want %h", c, oup2, exp[63:0]); end
                    holdPend = 1'b1;
                end
            end
            if (rowsPushed < 20 && q2.size() < 10) begin
                push2 = 1'b1; data2 = randRow();
                q2.push_back({1'b0, data2[63:0]});
                q2.push_back({1'b1, data2[127:64]});
                rowsPushed++;
            end else begin
                push2 = 1'b0;
            end
            if (rowsPushed == 20 && q2.size() == 0) done = 1'b1;
        end
        push2 = 1'b0;
        compared++; if (beats !== 40) begin mismatched++; $display("[TB] FAIL b2b_beat_count: got %0d want 40", beats); end
        @(negedge clk_i);
        compared++; if (valid2 !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_end_valid: got %b want 0", valid2); end
        compared++; if (usage2 !== 4'd0) begin mismatched++; $display("[TB] FAIL b2b_end_usage: got %0d want 0", usage2); end
        ready2 = 1'b0;
    endtask

    // Scenario sequence.
    initial begin
        $display("[TB] start");
        test_reset();
        test_single_row();
        test_split4();
        test_overflow();
        test_flush();
        test_full_push_pop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
